// File: rtl/multdiv_control.sv
// Sequencer for the iterative multiply/divide datapath: LOAD, N RUN steps, then DONE.
// Divide support (mode/rem_sign decode) is built only when MULTDIV_CONTROL_DIV_EN is defined.
module multdiv_control #(
    parameter int WIDTH  = 32,
    parameter int STEP_W = $clog2(WIDTH) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [2:0]        booth_bits,
    input  logic              rem_sign,
    output logic              busy,
    output logic              load,
    output logic              shift,
    output logic [2:0]        op,
    output logic [STEP_W-1:0] step,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_ADD2 = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_SUB2 = 3'd4;

    localparam logic [STEP_W-1:0] MUL_LAST = STEP_W'(WIDTH / 2 - 1);

    state_t            state_reg, state_next;
    logic [STEP_W-1:0] step_reg, step_next;
    logic [STEP_W-1:0] last_step;
    logic [2:0]        booth_op;

`ifdef MULTDIV_CONTROL_DIV_EN
    localparam logic [STEP_W-1:0] DIV_LAST = STEP_W'(WIDTH - 1);

    logic mode_reg, mode_next;

    assign last_step = mode_reg ? DIV_LAST : MUL_LAST;
`else
    logic unused_inputs;

    assign unused_inputs = ^{mode, rem_sign};
    assign last_step     = MUL_LAST;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            step_reg  <= '0;
`ifdef MULTDIV_CONTROL_DIV_EN
            mode_reg  <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            step_reg  <= step_next;
`ifdef MULTDIV_CONTROL_DIV_EN
            mode_reg  <= mode_next;
`endif
        end
    end

    // mode is captured only when a start is accepted (IDLE or DONE)
    always_comb begin
        state_next = state_reg;
        step_next  = step_reg;
`ifdef MULTDIV_CONTROL_DIV_EN
        mode_next  = mode_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                    step_next  = '0;
`ifdef MULTDIV_CONTROL_DIV_EN
                    mode_next  = mode;
`endif
                end
            end
            LOAD: begin
                state_next = RUN;
                step_next  = '0;
            end
            RUN: begin
                if (step_reg == last_step) begin
                    state_next = DONE;
                end else begin
                    step_next = step_reg + STEP_W'(1);
                end
            end
            DONE: begin
                if (start) begin
                    state_next = LOAD;
                    step_next  = '0;
`ifdef MULTDIV_CONTROL_DIV_EN
                    mode_next  = mode;
`endif
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // radix-4 Booth recoding of the current multiplier window
    always_comb begin
        booth_op = OP_NONE;
        case (booth_bits)
            3'b001, 3'b010: booth_op = OP_ADD;
            3'b011:         booth_op = OP_ADD2;
            3'b100:         booth_op = OP_SUB2;
            3'b101, 3'b110: booth_op = OP_SUB;
            default:        booth_op = OP_NONE;
        endcase
    end

    always_comb begin
        op = OP_NONE;
`ifdef MULTDIV_CONTROL_DIV_EN
        if (state_reg == RUN && mode_reg) begin
            op = (step_reg == '0 || !rem_sign) ? OP_SUB : OP_ADD;
        end else if (state_reg == RUN) begin
            op = booth_op;
        end else if (state_reg == DONE && mode_reg && rem_sign) begin
            op = OP_ADD;
        end
`else
        if (state_reg == RUN) begin
            op = booth_op;
        end
`endif
    end

    assign busy  = (state_reg != IDLE);
    assign load  = (state_reg == LOAD);
    assign shift = (state_reg == RUN);
    assign done  = (state_reg == DONE);
    assign step  = step_reg;

endmodule

// File: tb/tb_multdiv_control.sv
// Directed bench for multdiv_control: WIDTH=32, 8 and 4 instances share clock and reset.
// Divide expectations follow MULTDIV_CONTROL_DIV_EN.
module tb_multdiv_control;

    logic       clock = 1'b0;
    logic       reset;
    logic       mode;
    logic [2:0] booth_bits;
    logic       rem_sign;

    logic       start32, start8, start4;
    logic       busy32, load32, shift32, done32;
    logic       busy8, load8, shift8, done8;
    logic       busy4, load4, shift4, done4;
    logic [2:0] op32, op8, op4;
    logic [5:0] step32;
    logic [3:0] step8;
    logic [2:0] step4;

    int n_assert = 0;
    int n_fail   = 0;

`ifdef MULTDIV_CONTROL_DIV_EN
    localparam int   N8     = 8;
    localparam logic DIV_ON = 1'b1;
`else
    localparam int   N8     = 4;
    localparam logic DIV_ON = 1'b0;
`endif

    always #5 clock = ~clock;

    multdiv_control #(.WIDTH(32)) u32 (
        .clock(clock), .reset(reset), .start(start32), .mode(mode),
        .booth_bits(booth_bits), .rem_sign(rem_sign),
        .busy(busy32), .load(load32), .shift(shift32), .op(op32),
        .step(step32), .done(done32)
    );

    multdiv_control #(.WIDTH(8)) u8 (
        .clock(clock), .reset(reset), .start(start8), .mode(mode),
        .booth_bits(booth_bits), .rem_sign(rem_sign),
        .busy(busy8), .load(load8), .shift(shift8), .op(op8),
        .step(step8), .done(done8)
    );

    multdiv_control #(.WIDTH(4)) u4 (
        .clock(clock), .reset(reset), .start(start4), .mode(mode),
        .booth_bits(booth_bits), .rem_sign(rem_sign),
        .busy(busy4), .load(load4), .shift(shift4), .op(op4),
        .step(step4), .done(done4)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int booth_exp [8];
        int div_rem   [8];
        int div_exp   [8];
        int done_seen;
        int ph;

        booth_exp = '{0, 1, 1, 2, 4, 3, 3, 0};
        div_rem   = '{0, 1, 1, 0, 0, 1, 0, 1};
        div_exp   = '{3, 1, 1, 3, 3, 1, 3, 1};

        reset = 1'b0; mode = 1'b0; booth_bits = 3'b011; rem_sign = 1'b0;
        start32 = 1'b0; start8 = 1'b0; start4 = 1'b0;

        // reset state
        #12;
        chk("rst_busy",  busy32,  0);
        chk("rst_load",  load32,  0);
        chk("rst_shift", shift32, 0);
        chk("rst_op",    op32,    0);
        chk("rst_step",  step32,  0);
        chk("rst_done",  done32,  0);
        chk("rst_busy8", busy8,   0);
        chk("rst_busy4", busy4,   0);
        reset = 1'b1;
        tick();
        chk("idle_busy", busy32, 0);
        chk("idle_op",   op32,   0);

        // multiply, window 011 -> +2M for all 16 steps
        $display("txn: mul32 booth=011");
        start32 = 1'b1; tick(); start32 = 1'b0;
        chk("m_load",  load32,  1);
        chk("m_lbusy", busy32,  1);
        chk("m_lshft", shift32, 0);
        chk("m_lop",   op32,    0);
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("m_shift", shift32, 1);
            chk("m_op",    op32,    2);
            chk("m_step",  step32,  i);
            chk("m_nold",  load32,  0);
            chk("m_nodn",  done32,  0);
        end
        tick();
        chk("m_done",  done32,  1);
        chk("m_dshft", shift32, 0);
        chk("m_dop",   op32,    0);
        chk("m_dbusy", busy32,  1);
        chk("m_dstep", step32,  15);
        tick();
        chk("m_ibusy", busy32, 0);
        chk("m_idone", done32, 0);
        chk("m_istep", step32, 15);

        // Booth window sweep in LOAD, RUN, DONE, IDLE
        $display("txn: mul32 booth sweep");
        start32 = 1'b1; tick(); start32 = 1'b0;
        for (int b = 0; b < 8; b++) begin
            booth_bits = 3'(b); #1;
            chk("sw_load_op", op32, 0);
        end
        tick();
        for (int b = 0; b < 8; b++) begin
            booth_bits = 3'(b); #1;
            chk("sw_run_op", op32, booth_exp[b]);
        end
        booth_bits = 3'b011;
        repeat (15) tick();
        chk("sw_step15", step32, 15);
        tick();
        chk("sw_done", done32, 1);
        for (int b = 0; b < 8; b++) begin
            booth_bits = 3'(b); #1;
            chk("sw_done_op", op32, 0);
        end
        tick();
        for (int b = 0; b < 8; b++) begin
            booth_bits = 3'(b); #1;
            chk("sw_idle_op", op32, 0);
        end
        chk("sw_ibusy", busy32, 0);

        // divide on WIDTH=8; mode changed after acceptance must not matter
        $display("txn: div8 rem=0,1,1,0,0,1,0,1 div_en=%0d", DIV_ON);
        mode = 1'b1; booth_bits = 3'b100; rem_sign = 1'b1;
        start8 = 1'b1; tick(); start8 = 1'b0; mode = 1'b0;
        chk("d_load", load8, 1);
        tick();
        #1;
        chk("d_step0_op", op8, DIV_ON ? 3 : 4);
        for (int i = 0; i < N8; i++) begin
            if (i > 0) tick();
            rem_sign = div_rem[i]; #1;
            chk("d_shift", shift8, 1);
            chk("d_step",  step8,  i);
            chk("d_op",    op8,    DIV_ON ? div_exp[i] : 4);
        end
        tick();
        chk("d_done", done8, 1);
        rem_sign = 1'b1; #1;
        chk("d_corr_op", op8,    DIV_ON ? 1 : 0);
        chk("d_dshift",  shift8, 0);
        rem_sign = 1'b0; #1;
        chk("d_nocorr_op", op8, 0);
        tick();
        chk("d_ibusy", busy8, 0);

        // reset in the middle of RUN at step 5
        $display("txn: mul32 reset at step 5");
        mode = 1'b0; booth_bits = 3'b011;
        start32 = 1'b1; tick(); start32 = 1'b0;
        tick();
        repeat (5) tick();
        chk("r_step5",  step32,  5);
        chk("r_shift5", shift32, 1);
        reset = 1'b0; #1;
        chk("r_busy",  busy32,  0);
        chk("r_load",  load32,  0);
        chk("r_shift", shift32, 0);
        chk("r_op",    op32,    0);
        chk("r_step",  step32,  0);
        chk("r_done",  done32,  0);
        tick(); tick();
        reset = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done32) done_seen++;
        end
        chk("r_nodone", done_seen, 0);
        chk("r_idle",   busy32,    0);
        start32 = 1'b1; tick(); start32 = 1'b0;
        chk("r_reload", load32, 1);
        tick();
        chk("r_rstep0", step32,  0);
        chk("r_rshift", shift32, 1);
        repeat (16) tick();
        chk("r_rdone", done32, 1);
        tick();

        // WIDTH=4 with start held high: L,R0,R1,D repeating
        $display("txn: mul4 start held");
        booth_bits = 3'b010;
        start4 = 1'b1; tick();
        for (int k = 0; k < 8; k++) begin
            ph = k % 4;
            chk("h_load",  load4,  (ph == 0) ? 1 : 0);
            chk("h_shift", shift4, (ph == 1 || ph == 2) ? 1 : 0);
            chk("h_done",  done4,  (ph == 3) ? 1 : 0);
            chk("h_busy",  busy4,  1);
            if (ph == 1 || ph == 2) begin
                chk("h_step", step4, ph - 1);
                chk("h_op",   op4,   1);
            end
            tick();
        end
        start4 = 1'b0;
        chk("h_last_load", load4, 1);
        repeat (3) tick();
        chk("h_done_end", done4, 1);
        tick();
        chk("h_ibusy", busy4, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
